// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the main-memory line responder.
//   LINE_W_DEF  default line width (4 x 32-bit words)
//   WORD_W      word width inside a line
//   line_t      one cache line at the default width
//   mem_state_t responder FSM states
package mem_pkg;

  localparam int LINE_W_DEF = 128;
  localparam int WORD_W     = 32;

  typedef logic [LINE_W_DEF-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage : mem_pkg

// File: rtl/mem_line_responder_if.sv
// mem_line_responder_if: line request/response channel between the cache
// (master) and the main-memory responder (slave), plus the responder's
// completion counters.
//   req_valid_i / req_ready_o   request handshake
//   req_we_i                    1 = writeback, 0 = refill read
//   req_addr_i                  byte address, line-aligned use only
//   req_wdata_i                 writeback line
//   resp_valid_o / resp_ready_i response handshake
//   resp_we_o                   echo of the request type
//   resp_rdata_o                read line, zero for write responses
//   stat_rd_o / stat_wr_o       completed read / write counts
interface mem_line_responder_if #(
  parameter int LINE_W = mem_pkg::LINE_W_DEF
);

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [31:0]       req_addr_i;
  logic [LINE_W-1:0] req_wdata_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic              resp_we_o;
  logic [LINE_W-1:0] resp_rdata_o;
  logic [31:0]       stat_rd_o;
  logic [31:0]       stat_wr_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_we_o, resp_rdata_o,
           stat_rd_o, stat_wr_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_we_o, resp_rdata_o,
           stat_rd_o, stat_wr_o
  );

endinterface : mem_line_responder_if

// File: rtl/mem_line_array.sv
// mem_line_array: synchronous single-port line store, DEPTH x LINE_W.
//   clk_i  clock, rising edge
//   we     write enable, writes wdata to line idx
//   re     read enable, registers line idx into rdata
//   idx    line index
//   wdata  write line
//   rdata  registered read line (holds its value while re is low)
module mem_line_array #(
  parameter int LINE_W = mem_pkg::LINE_W_DEF,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset; resetting a memory
  // prevents RAM inference and the contents must survive a responder reset.
  always_ff @(posedge clk_i) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata    <= mem[idx];
  end

endmodule : mem_line_array

// File: rtl/mem_line_responder.sv
// mem_line_responder: fixed-latency main-memory responder for cache line
// refills and writebacks. One transaction outstanding at a time.
//   clk_i  clock, rising edge
//   rst_i  asynchronous, active-high reset
//   bus    mem_line_responder_if.slave request/response channel
// Parameters: LINE_W line width, DEPTH lines (power of two),
//             LATENCY cycles spent in WAIT (1..255).
// Build option: define MEM_STATS_EN to build the stat_rd_o/stat_wr_o
// completion counters; otherwise both read as zero.
module mem_line_responder
  import mem_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mem_line_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  mem_state_t        state;
  logic [7:0]        cnt;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [LINE_W-1:0] arr_rdata;

  logic handshake;
  logic commit;
  logic done;

  assign handshake = (state == IDLE) && bus.req_valid_i && req_ready_q;
  // The store is accessed exactly once, on the WAIT->RESP edge, so a
  // following read of the same line always sees the committed write.
  assign commit    = (state == WAIT) && (cnt == 8'd0);
  assign done      = (state == RESP) && bus.resp_ready_i;

  // Only the index field of the address matters; the byte offset and the
  // bits above the store size are dropped, which makes addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr_i[3:0], bus.req_addr_i[31:4+IDX_W]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            we_q        <= bus.req_we_i;
            idx_q       <= bus.req_addr_i[4 +: IDX_W];
            wdata_q     <= bus.req_wdata_i;
            cnt         <= 8'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state       <= WAIT;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  mem_line_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i (clk_i),
    .we    (commit && we_q),
    .re    (commit && !we_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign bus.req_ready_o  = req_ready_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_we_o    = we_q;
  // The array's read register holds across RESP; gating it keeps write
  // responses and the post-reset state at zero.
  assign bus.resp_rdata_o = (resp_valid_q && !we_q) ? arr_rdata : '0;

`ifdef MEM_STATS_EN
  logic [31:0] stat_rd_q;
  logic [31:0] stat_wr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_rd_q <= 32'h0;
      stat_wr_q <= 32'h0;
    end else if (done) begin
      if (we_q) stat_wr_q <= stat_wr_q + 32'h1;
      else      stat_rd_q <= stat_rd_q + 32'h1;
    end
  end

  assign bus.stat_rd_o = stat_rd_q;
  assign bus.stat_wr_o = stat_wr_q;
`else
  logic unused_done;
  assign unused_done   = done;
  assign bus.stat_rd_o = 32'h0;
  assign bus.stat_wr_o = 32'h0;
`endif

endmodule : mem_line_responder

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: randomized self-checking bench for
// mem_line_responder. Instance A (LATENCY=8, DEPTH=1024) covers latency,
// aliasing, backpressure and mid-transaction reset; instance B (LATENCY=1,
// DEPTH=16) covers back-to-back throughput. Expected stat values follow
// MEM_STATS_EN.
module tb_mem_line_responder;
  import mem_pkg::*;

  localparam int LAT_A   = 8;
  localparam int DEPTH_A = 1024;
  localparam int LAT_B   = 1;
  localparam int DEPTH_B = 16;
`ifdef MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam line_t PAT = 128'h11111111_22222222_33333333_44444444;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_line_responder_if #(.LINE_W(LINE_W_DEF)) bus_a ();
  mem_line_responder_if #(.LINE_W(LINE_W_DEF)) bus_b ();

  mem_line_responder #(.LINE_W(LINE_W_DEF), .DEPTH(DEPTH_A), .LATENCY(LAT_A)) dut_a (
    .clk_i (clk), .rst_i (rst), .bus (bus_a)
  );
  mem_line_responder #(.LINE_W(LINE_W_DEF), .DEPTH(DEPTH_B), .LATENCY(LAT_B)) dut_b (
    .clk_i (clk), .rst_i (rst), .bus (bus_b)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  line_t model [int];   // line index -> last committed data (instance A)
  int    exp_rd = 0;
  int    exp_wr = 0;
  line_t line_b [4];

  function automatic logic [31:0] exp_stat(input int n);
    return STATS ? 32'(n) : 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr(input int idx);
    // Random alias region above the store, random byte offset.
    return (32'($urandom_range(0, 3)) << 14) | (32'(idx) << 4) | 32'($urandom_range(0, 15));
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_a.req_valid_i = 1'b0; bus_a.req_we_i = 1'b0; bus_a.req_addr_i = '0;
    bus_a.req_wdata_i = '0;   bus_a.resp_ready_i = 1'b0;
    bus_b.req_valid_i = 1'b0; bus_b.req_we_i = 1'b0; bus_b.req_addr_i = '0;
    bus_b.req_wdata_i = '0;   bus_b.resp_ready_i = 1'b0;
  endtask

  task automatic wait_ready_a();
    int t = 0;
    while (!bus_a.req_ready_o && t < 50) begin @(negedge clk); t++; end
    check("a_ready_before_req", bus_a.req_ready_o, 1'b1);
  endtask

  // Full transaction on instance A, optionally stalling the response.
  task automatic txn_a(input bit we, input logic [31:0] addr, input line_t wdata, input int stall);
    int    lat;
    int    idx;
    bit    have_exp;
    line_t exp_data;
    line_t held;
    idx = int'((addr >> 4) % DEPTH_A);
    wait_ready_a();
    bus_a.req_valid_i  = 1'b1;
    bus_a.req_we_i     = we;
    bus_a.req_addr_i   = addr;
    bus_a.req_wdata_i  = wdata;
    bus_a.resp_ready_i = (stall == 0);
    if (we) model[idx] = wdata;
    have_exp = we || model.exists(idx);
    exp_data = (!we && model.exists(idx)) ? model[idx] : '0;
    @(negedge clk);
    lat = 1;
    // Scramble the request lines; only the handshake values may count.
    bus_a.req_valid_i = 1'b0;
    bus_a.req_we_i    = 1'($urandom);
    bus_a.req_addr_i  = $urandom;
    bus_a.req_wdata_i = {$urandom, $urandom, $urandom, $urandom};
    check("a_ready_in_wait", bus_a.req_ready_o, 1'b0);
    while (!bus_a.resp_valid_o && lat < LAT_A + 20) begin @(negedge clk); lat++; end
    check("a_latency", 128'(lat), 128'(LAT_A + 1));
    check("a_resp_we", bus_a.resp_we_o, we);
    if (have_exp) check("a_rdata", bus_a.resp_rdata_o, exp_data);
    held = bus_a.resp_rdata_o;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("a_stall_valid", bus_a.resp_valid_o, 1'b1);
      check("a_stall_rdata", bus_a.resp_rdata_o, held);
      check("a_stall_ready", bus_a.req_ready_o, 1'b0);
      check("a_stall_stat_rd", bus_a.stat_rd_o, exp_stat(exp_rd));
      check("a_stall_stat_wr", bus_a.stat_wr_o, exp_stat(exp_wr));
    end
    bus_a.resp_ready_i = 1'b1;
    @(negedge clk);
    if (we) exp_wr++; else exp_rd++;
    bus_a.resp_ready_i = 1'b0;
    check("a_valid_after_consume", bus_a.resp_valid_o, 1'b0);
    check("a_ready_after_consume", bus_a.req_ready_o, 1'b1);
    check("a_stat_rd", bus_a.stat_rd_o, exp_stat(exp_rd));
    check("a_stat_wr", bus_a.stat_wr_o, exp_stat(exp_wr));
  endtask

  // Start a transaction on A and reset in the middle of WAIT.
  task automatic abort_a(input bit we, input logic [31:0] addr, input line_t wdata,
                         input int wait_cycles, input int rst_cycles);
    bit saw;
    wait_ready_a();
    bus_a.req_valid_i = 1'b1;
    bus_a.req_we_i    = we;
    bus_a.req_addr_i  = addr;
    bus_a.req_wdata_i = wdata;
    bus_a.resp_ready_i = 1'b1;
    @(negedge clk);
    bus_a.req_valid_i = 1'b0;
    repeat (wait_cycles) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_ready", bus_a.req_ready_o, 1'b0);
    check("rst_stat_rd", bus_a.stat_rd_o, 32'h0);
    repeat (rst_cycles) @(negedge clk);
    rst = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    @(negedge clk);
    check("ready_after_release", bus_a.req_ready_o, 1'b1);
    saw = 1'b0;
    for (int i = 0; i < LAT_A + 6; i++) begin
      saw |= bus_a.resp_valid_o;
      @(negedge clk);
    end
    check("no_resp_after_abort", saw, 1'b0);
    check("abort_stat_rd", bus_a.stat_rd_o, 32'h0);
    check("abort_stat_wr", bus_a.stat_wr_o, 32'h0);
    bus_a.resp_ready_i = 1'b0;
  endtask

  // Stream n requests into instance B as fast as it accepts them.
  task automatic stream_b(input bit we, input int n);
    int issued = 0;
    int seen   = 0;
    int cyc    = 0;
    int last   = -1;
    bus_b.resp_ready_i = 1'b1;
    while (seen < n && cyc < 100) begin
      if (bus_b.resp_valid_o) begin
        check("b_resp_we", bus_b.resp_we_o, we);
        check("b_rdata", bus_b.resp_rdata_o, we ? line_t'(0) : line_b[seen]);
        if (last >= 0) check("b_spacing", 128'(cyc - last), 128'(LAT_B + 2));
        last = cyc;
        seen++;
      end
      if (issued < n && bus_b.req_ready_o) begin
        bus_b.req_valid_i = 1'b1;
        bus_b.req_we_i    = we;
        bus_b.req_addr_i  = 32'(issued) << 4;
        bus_b.req_wdata_i = line_b[issued];
        issued++;
      end else begin
        bus_b.req_valid_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("b_all_responses", 128'(seen), 128'(n));
    bus_b.req_valid_i  = 1'b0;
    bus_b.resp_ready_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    line_t d1;
    line_t d2;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready", bus_a.req_ready_o, 1'b0);
    check("reset_valid", bus_a.resp_valid_o, 1'b0);
    check("reset_we", bus_a.resp_we_o, 1'b0);
    check("reset_rdata", bus_a.resp_rdata_o, '0);
    check("reset_stat_rd", bus_a.stat_rd_o, 32'h0);
    check("reset_stat_wr", bus_a.stat_wr_o, 32'h0);
    check("reset_ready_b", bus_b.req_ready_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("release_ready", bus_a.req_ready_o, 1'b1);
    check("release_ready_b", bus_b.req_ready_o, 1'b1);

    // Write then read the same line.
    txn_a(1'b1, 32'h0000_0040, PAT, 0);
    txn_a(1'b0, 32'h0000_0040, '0, 0);

    // Aliasing: 0x4010 and 0x0010 are both line 1.
    d1 = {$urandom, $urandom, $urandom, $urandom};
    txn_a(1'b1, 32'h0000_4010, d1, 0);
    txn_a(1'b0, 32'h0000_0010, '0, 0);

    // Backpressure for 20 cycles.
    txn_a(1'b0, 32'h0000_0040, '0, 20);

    // Reset in the middle of a read.
    abort_a(1'b0, 32'h0000_0040, '0, 3, 5);

    // Reset in the middle of a write: the old line must survive.
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = ~d1;
    txn_a(1'b1, 32'h0000_0050, d1, 0);
    abort_a(1'b1, 32'h0000_0050, d2, 2, 3);
    txn_a(1'b0, 32'h0000_0050, '0, 0);

    // Randomized traffic over eight lines reached through alias addresses.
    for (int i = 0; i < 8; i++)
      txn_a(1'b1, rand_addr(i), {$urandom, $urandom, $urandom, $urandom}, 0);
    for (int i = 0; i < 24; i++)
      txn_a(1'($urandom), rand_addr($urandom_range(0, 7)),
            {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3));

    // Back-to-back at LATENCY=1.
    for (int i = 0; i < 4; i++) line_b[i] = {$urandom, $urandom, $urandom, $urandom};
    stream_b(1'b1, 4);
    check("b_stat_wr", bus_b.stat_wr_o, exp_stat(4));
    stream_b(1'b0, 4);
    check("b_stat_rd", bus_b.stat_rd_o, exp_stat(4));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_mem_line_responder
